// File: rtl/multiword_add_seq_if.sv
// Operation request / result bus for multiword_add_seq.
// The op_sub signal exists only when ALU_SUB_EN is defined.
interface multiword_add_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  nwords;
`ifdef ALU_SUB_EN
  logic        op_sub;
`endif
  logic [63:0] res;
  logic        res_valid;
  logic        res_ready;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;
  logic        busy;

  // Requester / result consumer side
  modport master (
    output start_valid, a, b, nwords, res_ready,
`ifdef ALU_SUB_EN
    output op_sub,
`endif
    input  start_ready, res, res_valid, sign, zero, carry, parity, overflow, busy
  );

  // Adder block side
  modport slave (
    input  start_valid, a, b, nwords, res_ready,
`ifdef ALU_SUB_EN
    input  op_sub,
`endif
    output start_ready, res, res_valid, sign, zero, carry, parity, overflow, busy
  );
endinterface

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: 16..64-bit add (optionally subtract) computed serially
// through a single 16-bit adder slice, one word per RUN cycle.
// Optional feature macro: ALU_SUB_EN (adds op_sub; B is inverted, carry-in 1).
module multiword_add_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  multiword_add_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_a;
  logic [63:0] r_b;      // effective second operand (already inverted for sub)
  logic [1:0]  r_nw;
  logic [1:0]  r_k;
  logic        r_c;
  logic [63:0] r_res;

  logic        w_accept;
  logic        w_sub;
  logic [63:0] w_b_eff;
  logic [15:0] w_a_k;
  logic [15:0] w_b_k;
  logic [16:0] w_sum;
  logic [5:0]  w_msb;
  logic        w_done;

`ifdef ALU_SUB_EN
  assign w_sub = bus.op_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && bus.start_valid;
  assign w_b_eff  = w_sub ? ~bus.b : bus.b;

  // The one adder slice: word k of both operands plus the running carry
  assign w_a_k = r_a[{r_k, 4'b0000} +: 16];
  assign w_b_k = r_b[{r_k, 4'b0000} +: 16];
  assign w_sum = {1'b0, w_a_k} + {1'b0, w_b_k} + {16'b0, r_c};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: accept from IDLE, finish after word nwords, release on res_ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_valid)  w_next = RUN;
      RUN:     if (r_k == r_nw)      w_next = DONE;
      DONE:    if (bus.res_ready)    w_next = IDLE;
      default:                       w_next = IDLE;
    endcase
  end

  // Operand latch on accept, word-serial accumulate during RUN, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_nw  <= '0;
      r_k   <= '0;
      r_c   <= 1'b0;
      r_res <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= w_b_eff;
      r_nw  <= bus.nwords;
      r_k   <= '0;
      r_c   <= w_sub;    // carry-in 1 turns ~B into -B
      r_res <= '0;       // inactive words stay zero
    end else if (r_state == RUN) begin
      r_res[{r_k, 4'b0000} +: 16] <= w_sum[15:0];
      r_c   <= w_sum[16];
      r_k   <= r_k + 2'd1;
    end
  end

  // Flags look only at the active width; words above it are already zero,
  // so whole-vector zero/parity reductions match the active-width ones.
  assign w_msb  = {r_nw, 4'hF};
  assign w_done = (r_state == DONE);

  assign bus.start_ready = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.res_valid   = w_done;
  assign bus.res         = r_res;
  assign bus.sign        = w_done & r_res[w_msb];
  assign bus.zero        = w_done & (r_res == 64'd0);
  assign bus.carry       = w_done & r_c;
  assign bus.parity      = w_done & ~(^r_res);
  assign bus.overflow    = w_done & (( r_a[w_msb] &  r_b[w_msb] & ~r_res[w_msb]) |
                                     (~r_a[w_msb] & ~r_b[w_msb] &  r_res[w_msb]));

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq.
// Flags are compared as the vector {sign, zero, carry, parity, overflow}.
module tb_multiword_add_seq;
  logic clk;
  logic rst_n;
  int   ntests;
  int   nfail;
  int   cyc;

  multiword_add_seq_if bus();

  multiword_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
  endfunction

  // Present an operation at a negedge; returns #1 after the accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] nw, input logic sub, input logic keep);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.nwords = nw;
`ifdef ALU_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("[TB] op_sub request ignored in add-only build");
`endif
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) bus.start_valid = 1'b0;
    chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  // Counts cycles from the accept edge (the accept edge counts as 1).
  task automatic wait_done(input string tag, input int exp_cyc);
    cyc = 1;
    while (!bus.res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic release_res();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("idle_after_ready", {62'd0, bus.start_ready, bus.res_valid}, 64'b10);
  endtask

  initial begin
    ntests = 0; nfail = 0;
    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.a = '0; bus.b = '0; bus.nwords = '0; bus.res_ready = 1'b0;
`ifdef ALU_SUB_EN
    bus.op_sub = 1'b0;
`endif
    #12;
    // Reset state
    chk("rst_ready_busy_valid", {61'd0, bus.start_ready, bus.busy, bus.res_valid}, 64'b100);
    chk("rst_res", bus.res, 64'd0);
    chk("rst_flags", {59'd0, flags()}, 64'd0);
    rst_n = 1'b1;

    // res_ready in IDLE has no effect
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
    chk("ready_in_idle", {62'd0, bus.start_ready, bus.busy}, 64'b10);

    // 16-bit signed overflow: 7FFF + 1
    start_op(64'h7FFF, 64'h0001, 2'd0, 1'b0, 1'b0);
    wait_done("lat16", 2);
    chk("res16", bus.res, 64'h8000);
    chk("flags16", {59'd0, flags()}, 64'b10001);
    release_res();

    // 64-bit all-ones + 1 wraps to zero with carry out
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 1'b0, 1'b0);
    wait_done("lat64", 5);
    chk("res64", bus.res, 64'd0);
    chk("flags64", {59'd0, flags()}, 64'b01110);
    release_res();

    // 32-bit carry across words, operands changed mid-flight, result held
    start_op(64'h0000_FFFF, 64'h0000_0001, 2'd1, 1'b0, 1'b0);
    bus.a = 64'hDEAD_BEEF_DEAD_BEEF; bus.b = 64'h1111_2222_3333_4444; bus.nwords = 2'd3;
    wait_done("lat32", 3);
    for (int i = 0; i < 3; i++) begin
      chk("hold_res32", bus.res, 64'h0001_0000);
      chk("hold_flags32", {59'd0, flags()}, 64'b00000);
      chk("hold_rdy_vld32", {62'd0, bus.start_ready, bus.res_valid}, 64'b01);
      @(posedge clk); #1;
    end
    release_res();

    // 48-bit: carry through middle word, sign overflow at bit 47
    start_op(64'h0000_7FFF_FFFF_0000, 64'h0000_0000_0001_0000, 2'd2, 1'b0, 1'b0);
    wait_done("lat48", 4);
    chk("res48", bus.res, 64'h0000_8000_0000_0000);
    chk("flags48", {59'd0, flags()}, 64'b10001);
    release_res();

    // 16-bit with junk in upper operand words: upper result bits must be 0
    start_op(64'hFFFF_FFFF_FFFF_0003, 64'h1234_0000_0000_0005, 2'd0, 1'b0, 1'b0);
    wait_done("lat16b", 2);
    chk("res16_upper_zero", bus.res, 64'h0000_0000_0000_0008);
    chk("flags16b", {59'd0, flags()}, 64'b00000);
    release_res();

    // Reset in 2nd RUN cycle of a 64-bit add, then accept on first edge after release
    start_op(64'd1, 64'd1, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort_ctl", {60'd0, bus.start_ready, bus.busy, bus.res_valid, 1'b0}, 64'b1000);
    chk("abort_res", bus.res, 64'd0);
    chk("abort_flags", {59'd0, flags()}, 64'd0);
    #1 rst_n = 1'b1;
    start_op(64'h00FF, 64'h0001, 2'd0, 1'b0, 1'b0);
    wait_done("lat_after_rst", 2);
    chk("res_after_rst", bus.res, 64'h0100);
    chk("flags_after_rst", {59'd0, flags()}, 64'b00000);
    release_res();

    // start_valid held high: one op per IDLE visit, no bypass from DONE
    start_op(64'd1, 64'd2, 2'd0, 1'b0, 1'b1);
    wait_done("lat_hold_sv", 2);
    chk("res_hold_sv", bus.res, 64'd3);
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
    chk("no_bypass", {62'd0, bus.start_ready, bus.busy}, 64'b10);
    @(posedge clk); #1; bus.start_valid = 1'b0;
    chk("reaccept", {62'd0, bus.start_ready, bus.busy}, 64'b01);
    wait_done("lat_reaccept", 2);
    chk("res_reaccept", bus.res, 64'd3);
    release_res();

    // 5 - 7 on 32 bits (subtract build) or 5 + 7 (add-only build)
    start_op(64'd5, 64'd7, 2'd1, 1'b1, 1'b0);
    wait_done("lat_sub", 3);
`ifdef ALU_SUB_EN
    chk("res_sub", bus.res, 64'hFFFF_FFFE);
    chk("flags_sub", {59'd0, flags()}, 64'b10000);
`else
    chk("res_addonly", bus.res, 64'd12);
    chk("flags_addonly", {59'd0, flags()}, 64'b00010);
`endif
    release_res();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-002 The block SHALL provide these operation ports:
- start_valid  input  1  operation request
- start_ready  output  1  block can accept a request
- a  input  64  operand A; word k = a[16k+15:16k]
- b  input  64  operand B; word k = b[16k+15:16k]
- nwords  input  2  active words minus 1 (0 = 16-bit, 1 = 32-bit, 2 = 48-bit, 3 = 64-bit)
- op_sub  input  1  subtract request; present only under ALU_SUB_EN
REQ-003 The block SHALL provide these result ports:
- res  output  64  result
- res_valid  output  1  result and flags valid
- res_ready  input  1  consumer accepts the result
- sign, zero, carry, parity, overflow  output  1 each  status flags
- busy  output  1  high in RUN or DONE

Function
REQ-004 The FSM SHALL have three states (IDLE, RUN, DONE); start_ready SHALL equal (state == IDLE).
REQ-005 In IDLE, start_valid=1 SHALL latch a, b, nwords and op_sub, clear the word index k and the carry register, and enter RUN.
REQ-006 The block SHALL contain exactly one 16-bit adder slice (carry-in, carry-out), used once per RUN cycle.
REQ-007 Each RUN cycle SHALL compute {c, res word k} = A_k + B_k + c, then increment k.
REQ-008 When k == nwords, the block SHALL enter DONE on the next edge.
REQ-009 The result SHALL be valid on the cycle after the final RUN cycle, so res_valid asserts exactly nwords+2 cycles after the accept edge.
REQ-010 res bits above 16*(nwords+1)-1 SHALL be 0.
REQ-011 Flags SHALL be computed over the active width W = 16*(nwords+1) only, and SHALL be stable while res_valid=1:
- sign = res[W-1]
- zero = 1 when all active bits are 0
- parity = XNOR of the active bits (even parity)
- carry = final carry-out
- overflow = (A[W-1] & B'[W-1] & ~res[W-1]) | (~A[W-1] & ~B'[W-1] & res[W-1]), where B' is the effective second operand
REQ-012 In DONE, res_valid SHALL be 1 and res and the flags SHALL hold until res_ready=1; the FSM then returns to IDLE on that edge.
REQ-013 start_valid during RUN or DONE SHALL be ignored; there is no same-cycle bypass from DONE to a new accept, so the next accept is at the earliest one cycle after leaving DONE.
REQ-014 res_ready outside DONE SHALL have no effect.
REQ-015 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL NOT affect the operation in flight.

Reset
REQ-016 rst_n=0 SHALL asynchronously force state IDLE, k=0, the carry register to 0, and res and all flags, res_valid and busy to 0.
REQ-017 start_ready SHALL be 1 during reset and after reset.
REQ-018 Reset during RUN or DONE SHALL abort the operation with no result delivered.
REQ-019 The first accept after reset release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-020 Macro ALU_SUB_EN SHALL control subtraction support.
- Defined: the op_sub port SHALL exist. When op_sub=1 is latched, B' = ~B, the initial carry SHALL be 1, and carry = final carry-out (1 means no borrow).
- Undefined: the op_sub port SHALL be absent and the block SHALL perform addition only, with B' = B and an initial carry of 0.

Verification
REQ-021 nwords=0, a=0x7FFF, b=0x0001 -> res=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0, and res_valid 2 cycles after accept.
REQ-022 nwords=3, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> res=0, zero=1, carry=1, overflow=0, parity=1, and res_valid 5 cycles after accept.
REQ-023 nwords=1, a=0x0000_FFFF, b=0x0000_0001, res_ready held 0 for 3 cycles -> res=0x0001_0000, carry propagates across words, res and flags held stable, start_ready=0 throughout, and IDLE on the res_ready=1 edge.
REQ-024 rst_n pulsed low in the 2nd RUN cycle of a 64-bit add -> all outputs 0 immediately, no res_valid, and a new 16-bit add accepted right after release completes correctly.
REQ-025 With ALU_SUB_EN, nwords=1, op_sub=1, a=5, b=7 -> res=0xFFFF_FFFE, sign=1, carry=0, overflow=0; without ALU_SUB_EN, the same operands give res=12.
REQ-026 start_valid held 1 through RUN and DONE -> exactly one operation per IDLE visit, and res_ready with start_valid in DONE does not cause a same-cycle accept.
